mips_div_unit: RTL and testbench

- Multi-cycle iterative integer divider; the inverse operation of the single-cycle ALU multiply path.
- Serves MIPS DIV/DIVU: quotient goes to LO, remainder goes to HI.
- Sits beside the ALU in the execute stage. The decode/hazard logic issues a start pulse and stalls on busy until done.
- Restoring division, one quotient bit per cycle, with sign pre/post-correction.

---
 rtl/mips_div_unit.sv | 142 ++++++++++++++
 tb/tb_mips_div_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mips_div_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : mips_div_unit                                                |
// | Purpose : Multi-cycle restoring divider for MIPS DIV/DIVU. Quotient    |
// |           feeds LO, remainder feeds HI. Operands are divided as        |
// |           magnitudes and the signs are fixed up afterwards.            |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module mips_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  div_start,
  input  logic                  div_signed,
  input  logic [DATA_WIDTH-1:0] div_op_x,
  input  logic [DATA_WIDTH-1:0] div_op_y,
  output logic                  div_busy,
  output logic                  div_done,
  output logic [DATA_WIDTH-1:0] div_quotient,
  output logic [DATA_WIDTH-1:0] div_remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic                  r_xs;
  logic                  r_ys;
  logic                  r_yzero;
  logic [DATA_WIDTH-1:0] r_x_orig;
  logic [DATA_WIDTH-1:0] r_ymag;
  logic [DATA_WIDTH-1:0] r_quo;
  logic [DATA_WIDTH-1:0] r_rem;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_accept;
  logic                  w_xs;
  logic                  w_ys;
  logic [DATA_WIDTH:0]   w_diff;
  logic [DATA_WIDTH-1:0] w_q_fix;
  logic [DATA_WIDTH-1:0] w_r_fix;

  // A new request is only taken when nothing is in flight (IDLE or DONE).
  assign w_accept = div_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_xs     = div_signed & div_op_x[DATA_WIDTH-1];
  assign w_ys     = div_signed & div_op_y[DATA_WIDTH-1];

  // Trial subtraction on the (DATA_WIDTH+1)-bit shifted partial remainder.
  // The working remainder is always below 2*|y|, so the difference fits in
  // DATA_WIDTH+1 signed bits and its MSB is the "trial went negative" flag.
  // Only the low DATA_WIDTH bits need storing since the kept value is < |y|.
  assign w_diff  = {r_rem, r_quo[DATA_WIDTH-1]} - {1'b0, r_ymag};

  // Sign post-correction: quotient sign is xs^ys, remainder follows dividend.
  assign w_q_fix = (r_xs ^ r_ys) ? -r_quo : r_quo;
  assign w_r_fix = r_xs ? -r_rem : r_rem;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and status outputs.
  always_comb begin
    w_state_nxt = r_state;
    div_busy    = 1'b0;
    div_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_CALC;
      end
      S_CALC: begin
        div_busy = 1'b1;
        if (r_cnt == '0) w_state_nxt = S_FIXUP;
      end
      S_FIXUP: begin
        div_busy    = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        div_done    = 1'b1;
        w_state_nxt = w_accept ? S_CALC : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture and one restoring-division step per CALC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xs     <= 1'b0;
      r_ys     <= 1'b0;
      r_yzero  <= 1'b0;
      r_x_orig <= '0;
      r_ymag   <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_xs     <= w_xs;
      r_ys     <= w_ys;
      r_yzero  <= (div_op_y == '0);
      r_x_orig <= div_op_x;
      r_ymag   <= w_ys ? -div_op_y : div_op_y;
      r_quo    <= w_xs ? -div_op_x : div_op_x;
      r_rem    <= '0;
      r_cnt    <= CNT_INIT;
    end else if (r_state == S_CALC) begin
      r_quo <= {r_quo[DATA_WIDTH-2:0], ~w_diff[DATA_WIDTH]};
      r_rem <= w_diff[DATA_WIDTH] ? {r_rem[DATA_WIDTH-2:0], r_quo[DATA_WIDTH-1]}
                                  : w_diff[DATA_WIDTH-1:0];
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Result registers load on the FIXUP->DONE edge and hold until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_quotient  <= '0;
      div_remainder <= '0;
      div_by_zero   <= 1'b0;
    end else if (r_state == S_FIXUP) begin
      div_quotient  <= r_yzero ? '1 : w_q_fix;
      div_remainder <= r_yzero ? r_x_orig : w_r_fix;
      div_by_zero   <= r_yzero;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_div_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_mips_div_unit                                             |
// | Purpose : Self-checking bench for mips_div_unit: directed corner cases,|
// |           timing, back-to-back issue, async reset and random operands  |
// |           against an arithmetic reference model.                       |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_mips_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_op_x;
  logic [31:0] div_op_y;
  logic        div_busy;
  logic        div_done;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  mips_div_unit #(.DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .div_start    (div_start),
    .div_signed   (div_signed),
    .div_op_x     (div_op_x),
    .div_op_y     (div_op_y),
    .div_busy     (div_busy),
    .div_done     (div_done),
    .div_quotient (div_quotient),
    .div_remainder(div_remainder),
    .div_by_zero  (div_by_zero)
  );

  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // MIPS DIV/DIVU semantics from plain arithmetic.
  function automatic void model(input bit sgn, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] q, output logic [31:0] r, output bit z);
    z = 1'b0;
    if (y == 32'd0) begin
      q = 32'hFFFF_FFFF; r = x; z = 1'b1;
    end else if (sgn) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000; r = 32'd0;
      end else begin
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
      end
    end else begin
      q = x / y;
      r = x % y;
    end
  endfunction

  // Issue one operation and check busy/done timing, results and hold.
  task automatic do_op(input bit sgn, input logic [31:0] x, input logic [31:0] y, input string tag);
    logic [31:0] eq, er;
    bit          ez;
    model(sgn, x, y, eq, er, ez);
    @(negedge clk);
    div_start = 1'b1; div_signed = sgn; div_op_x = x; div_op_y = y;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      div_start = 1'b0; div_signed = $urandom; div_op_x = $urandom; div_op_y = $urandom;
      check({tag, " busy/done"}, {30'd0, div_busy, div_done}, 32'd2);
    end
    @(negedge clk);
    check({tag, " done"}, {30'd0, div_busy, div_done}, 32'd1);
    check({tag, " quotient"}, div_quotient, eq);
    check({tag, " remainder"}, div_remainder, er);
    check({tag, " by_zero"}, {31'd0, div_by_zero}, {31'd0, ez});
    @(negedge clk);
    check({tag, " done pulse"}, {30'd0, div_busy, div_done}, 32'd0);
    check({tag, " quotient held"}, div_quotient, eq);
    check({tag, " remainder held"}, div_remainder, er);
  endtask

  initial begin
    logic [31:0] rx, ry;
    bit          rs;
    bit          saw_done;

    rst = 1'b1; div_start = 1'b0; div_signed = 1'b0; div_op_x = '0; div_op_y = '0;
    repeat (2) @(negedge clk);
    check("reset busy/done", {30'd0, div_busy, div_done}, 32'd0);
    check("reset quotient", div_quotient, 32'd0);
    check("reset remainder", div_remainder, 32'd0);
    check("reset by_zero", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;

    // Directed corner cases.
    do_op(1'b0, 32'd100, 32'd7, "divu 100/7");
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, "div -7/2");
    do_op(1'b1, 32'd7, 32'hFFFF_FFFE, "div 7/-2");
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div min/-1");
    do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "divu min/max");
    do_op(1'b0, 32'h1234_5678, 32'd0, "divu by zero");
    do_op(1'b1, 32'h1234_5678, 32'd0, "div by zero");

    // Random operands with a mix of divisor magnitudes.
    for (int i = 0; i < 24; i++) begin
      rs = $urandom_range(0, 1);
      rx = $urandom;
      case ($urandom_range(0, 3))
        0:       ry = $urandom;
        1:       ry = $urandom_range(1, 255);
        2:       ry = -$urandom_range(1, 255);
        default: ry = ($urandom_range(0, 2) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      endcase
      do_op(rs, rx, ry, $sformatf("rand%0d", i));
    end

    // Start held high through busy with changing operands, then a new
    // request in the DONE cycle.
    @(negedge clk);
    div_start = 1'b1; div_signed = 1'b0; div_op_x = 32'd100; div_op_y = 32'd7;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      div_signed = $urandom; div_op_x = $urandom; div_op_y = $urandom;
      check("b2b first busy", {30'd0, div_busy, div_done}, 32'd2);
    end
    @(negedge clk);
    check("b2b first done", {30'd0, div_busy, div_done}, 32'd1);
    check("b2b first quotient", div_quotient, 32'd14);
    check("b2b first remainder", div_remainder, 32'd2);
    div_start = 1'b1; div_signed = 1'b0; div_op_x = 32'd50; div_op_y = 32'd5;
    for (int c = 35; c <= 67; c++) begin
      @(negedge clk);
      div_start = 1'b0;
      check("b2b second busy", {30'd0, div_busy, div_done}, 32'd2);
      check("b2b old quotient held", div_quotient, 32'd14);
    end
    @(negedge clk);
    check("b2b second done", {30'd0, div_busy, div_done}, 32'd1);
    check("b2b second quotient", div_quotient, 32'd10);
    check("b2b second remainder", div_remainder, 32'd0);
    check("b2b second by_zero", {31'd0, div_by_zero}, 32'd0);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    div_start = 1'b1; div_signed = 1'b0; div_op_x = 32'd1000; div_op_y = 32'd3;
    @(negedge clk);
    div_start = 1'b0;
    repeat (9) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async rst busy/done", {30'd0, div_busy, div_done}, 32'd0);
    check("async rst quotient", div_quotient, 32'd0);
    check("async rst remainder", div_remainder, 32'd0);
    check("async rst by_zero", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (div_done || div_busy) saw_done = 1'b1;
    end
    check("no done after rst", {31'd0, saw_done}, 32'd0);
    do_op(1'b1, 32'hFFFF_FC18, 32'd3, "post-rst div");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
